// File: rtl/nanorv32_reset_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_reset_pkg
//  Description : Shared cause codes, FSM state encoding and counter sizing
//                for the nanorv32 reset controller.
//  Revision    : 1.0  initial release
// ============================================================================
package nanorv32_reset_pkg;

    // Reset cause codes reported to software
    localparam logic [2:0] CAUSE_NONE = 3'd0;
    localparam logic [2:0] CAUSE_POR  = 3'd1;
    localparam logic [2:0] CAUSE_EXT  = 3'd2;
    localparam logic [2:0] CAUSE_WDT  = 3'd3;
    localparam logic [2:0] CAUSE_SW   = 3'd4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // Counter must reach the last release point plus one without wrapping
    function automatic int cnt_width(input int stretch, input int domains, input int gap);
        return $clog2(stretch + domains * gap + 1);
    endfunction

    // Relative importance of a cause: POR outranks EXT, then WDT, then SW
    function automatic logic [2:0] cause_rank(input logic [2:0] cause);
        case (cause)
            CAUSE_POR: return 3'd4;
            CAUSE_EXT: return 3'd3;
            CAUSE_WDT: return 3'd2;
            CAUSE_SW:  return 3'd1;
            default:   return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/nanorv32_reset_sync.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_reset_sync
//  Description : Flop chain bringing an asynchronous level into the clk
//                domain. Clears to 0 on reset so an active-low input reads
//                as asserted until the chain has filled.
//  Revision    : 1.0  initial release
// ============================================================================
module nanorv32_reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Shift the asynchronous level through the chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/nanorv32_reset_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nanorv32_reset_ctrl
//  Description : Merges power-on, external, watchdog and software reset
//                sources into stretched, sequenced per-domain resets and
//                records the cause of the last reset.
//  Revision    : 1.0  initial release
// ============================================================================
module nanorv32_reset_ctrl
    import nanorv32_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int SEQ_GAP        = 4,
    parameter int NUM_DOMAINS    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ext_reset_n,
    input  logic                   wdt_reset_req,
    input  logic                   sw_reset_req,
    input  logic                   cause_clr,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   reset_done,
    output logic [2:0]             reset_cause
);

    localparam int c_cnt_w = cnt_width(STRETCH_CYCLES, NUM_DOMAINS, SEQ_GAP);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STRETCH_CYCLES + NUM_DOMAINS * SEQ_GAP);
    localparam logic [c_cnt_w-1:0] c_first   = c_cnt_w'(STRETCH_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(STRETCH_CYCLES + (NUM_DOMAINS - 1) * SEQ_GAP);

    state_t                   r_state, w_state_nxt;
    logic [c_cnt_w-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [NUM_DOMAINS-1:0]   r_rst_out, w_rst_nxt;
    logic                     r_done, w_done_nxt;
    logic [2:0]               r_cause, w_cause_nxt, w_src_cause;
    logic                     w_sync_q, w_ext_act, w_src_act;

    nanorv32_reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ext_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (ext_reset_n),
        .o_sync  (w_sync_q)
    );

    assign w_ext_act   = ~w_sync_q;
    assign w_src_act   = w_ext_act | wdt_reset_req | sw_reset_req;
    assign w_src_cause = w_ext_act     ? CAUSE_EXT :
                         wdt_reset_req ? CAUSE_WDT : CAUSE_SW;
    assign w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_w'(1);

    // Sequencer next state: any active source restarts from ASSERT
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rst_nxt   = r_rst_out;
        w_done_nxt  = r_done;
        if (w_src_act) begin
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = '0;
            w_rst_nxt   = '1;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_state_nxt = ST_STRETCH;
                    w_cnt_nxt   = '0;
                    w_rst_nxt   = '1;
                end
                ST_STRETCH: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_first) begin
                        w_rst_nxt[0] = 1'b0;
                        w_state_nxt  = (w_cnt_inc == c_last) ? ST_RUN : ST_RELEASE;
                        w_done_nxt   = (w_cnt_inc == c_last);
                    end
                end
                ST_RELEASE: begin
                    w_cnt_nxt = w_cnt_inc;
                    for (int i = 1; i < NUM_DOMAINS; i++) begin
                        if (w_cnt_inc == c_cnt_w'(STRETCH_CYCLES + i * SEQ_GAP)) begin
                            w_rst_nxt[i] = 1'b0;
                        end
                    end
                    if (w_cnt_inc == c_last) begin
                        w_state_nxt = ST_RUN;
                        w_done_nxt  = 1'b1;
                    end
                end
                ST_RUN: begin
                    w_rst_nxt  = '0;
                    w_done_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                    w_cnt_nxt   = '0;
                    w_rst_nxt   = '1;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Cause capture: new sources overwrite outside ASSERT, only stronger ones inside
    always_comb begin
        w_cause_nxt = r_cause;
        if (w_src_act) begin
            if (r_state != ST_ASSERT || cause_rank(w_src_cause) > cause_rank(r_cause)) begin
                w_cause_nxt = w_src_cause;
            end
        end else if (cause_clr && r_state == ST_RUN) begin
            w_cause_nxt = CAUSE_NONE;
        end
    end

    // State and output registers; power-on reset forces all domains into reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ASSERT;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_cause   <= CAUSE_POR;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_out <= w_rst_nxt;
            r_done    <= w_done_nxt;
            r_cause   <= w_cause_nxt;
        end
    end

    assign rst_out     = r_rst_out;
    assign reset_done  = r_done;
    assign reset_cause = r_cause;

endmodule
`default_nettype wire
